// File: rtl/aes_keyexp_engine.sv
// AES-128 key expansion bus master: reads key, S-box and Rcon from data memory and writes w[0..43] back.
// Optional build macro KEYEXP_CHECKSUM_EN adds an XOR checksum of every written word on rk_xsum.
module aes_keyexp_engine #(
  parameter logic [8:0] KEY_BASE  = 9'd4,
  parameter logic [8:0] SBOX_BASE = 9'd8,
  parameter logic [8:0] RCON_BASE = 9'd72,
  parameter logic [8:0] RK_BASE   = 9'd128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        mem_wen,
  output logic [8:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic [31:0] rk_xsum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDKEY = 3'd1,
    S_CPKEY = 3'd2,
    S_SUB   = 3'd3,
    S_RCON  = 3'd4,
    S_WR    = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e            state_q;
  logic [5:0]        i_q;
  logic [1:0]        k_q;
  logic [3:0][31:0]  w_q;      // w_q[0] = w[i-4] ... w_q[3] = w[i-1]
  logic [31:0]       sub_q;
  logic [31:0]       temp_q;
  logic              busy_q;
  logic              done_q;

  logic [31:0] rot_s;
  logic [7:0]  sbyte_s;
  logic [7:0]  lane_s;
  logic [31:0] wr_word_s;
  logic [3:0]  rcon_idx_s;
  logic        mem_wen_s;
  logic [8:0]  mem_addr_s;
  logic [31:0] mem_din_s;

  // S-box byte selection and new round-key word
  always_comb begin
    rot_s      = {w_q[3][23:0], w_q[3][31:24]};
    rcon_idx_s = i_q[5:2] - 4'd1;
    case (k_q)
      2'd0:    sbyte_s = rot_s[31:24];
      2'd1:    sbyte_s = rot_s[23:16];
      2'd2:    sbyte_s = rot_s[15:8];
      default: sbyte_s = rot_s[7:0];
    endcase
    case (sbyte_s[1:0])
      2'd0:    lane_s = mem_dout[31:24];
      2'd1:    lane_s = mem_dout[23:16];
      2'd2:    lane_s = mem_dout[15:8];
      default: lane_s = mem_dout[7:0];
    endcase
    if (i_q[1:0] == 2'd0) begin
      wr_word_s = w_q[0] ^ temp_q;
    end else begin
      wr_word_s = w_q[0] ^ w_q[3];
    end
  end

  // Memory port decode from state, counter and window registers only
  always_comb begin
    mem_wen_s  = 1'b0;
    mem_addr_s = 9'd0;
    mem_din_s  = 32'd0;
    case (state_q)
      S_LDKEY: mem_addr_s = KEY_BASE + {3'd0, i_q};
      S_CPKEY: begin
        mem_wen_s  = 1'b1;
        mem_addr_s = RK_BASE + {3'd0, i_q};
        mem_din_s  = w_q[i_q[1:0]];
      end
      S_SUB:   mem_addr_s = SBOX_BASE + {3'd0, sbyte_s[7:2]};
      S_RCON:  mem_addr_s = RCON_BASE + {5'd0, rcon_idx_s};
      S_WR: begin
        mem_wen_s  = 1'b1;
        mem_addr_s = RK_BASE + {3'd0, i_q};
        mem_din_s  = wr_word_s;
      end
      default: begin
        mem_wen_s  = 1'b0;
        mem_addr_s = 9'd0;
        mem_din_s  = 32'd0;
      end
    endcase
  end

  // Expansion FSM with window, substitution and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= 6'd0;
      k_q     <= 2'd0;
      w_q     <= '0;
      sub_q   <= 32'd0;
      temp_q  <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LDKEY;
            i_q     <= 6'd0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LDKEY: begin
          w_q <= {mem_dout, w_q[3:1]};
          if (i_q == 6'd3) begin
            state_q <= S_CPKEY;
            i_q     <= 6'd0;
          end else begin
            i_q <= i_q + 6'd1;
          end
        end
        S_CPKEY: begin
          if (i_q == 6'd3) begin
            state_q <= S_SUB;
            i_q     <= 6'd4;
            k_q     <= 2'd0;
          end else begin
            i_q <= i_q + 6'd1;
          end
        end
        S_SUB: begin
          case (k_q)
            2'd0:    sub_q[31:24] <= lane_s;
            2'd1:    sub_q[23:16] <= lane_s;
            2'd2:    sub_q[15:8]  <= lane_s;
            default: sub_q[7:0]   <= lane_s;
          endcase
          if (k_q == 2'd3) begin
            state_q <= S_RCON;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        S_RCON: begin
          temp_q  <= sub_q ^ mem_dout;
          state_q <= S_WR;
        end
        S_WR: begin
          w_q <= {wr_word_s, w_q[3:1]};
          if (i_q == 6'd43) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            i_q <= i_q + 6'd1;
            if (i_q[1:0] == 2'd3) begin
              state_q <= S_SUB;
              k_q     <= 2'd0;
            end else begin
              state_q <= S_WR;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_wen  = mem_wen_s;
  assign mem_addr = mem_addr_s;
  assign mem_din  = mem_din_s;

`ifdef KEYEXP_CHECKSUM_EN
  logic [31:0] xsum_q;

  // Running XOR of every word written during a run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xsum_q <= 32'd0;
    end else if ((state_q == S_IDLE) && start) begin
      xsum_q <= 32'd0;
    end else if (mem_wen_s) begin
      xsum_q <= xsum_q ^ mem_din_s;
    end else begin
      xsum_q <= xsum_q;
    end
  end

  assign rk_xsum = xsum_q;
`else
  assign rk_xsum = 32'h0;
`endif

endmodule

// File: tb/tb_aes_keyexp_engine.sv
// Scoreboard bench for aes_keyexp_engine: a behavioural data memory, directed key vectors,
// and a negedge monitor checking every write and every done pulse against queued expectations.
module tb_aes_keyexp_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic        mem_wen;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [31:0] rk_xsum;

  logic [31:0] mem [512];
  logic [31:0] sbox_w [64];

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
    logic        care;
  } wr_t;

  wr_t wq[$];
  int  rq[$];

  int n_checks = 0;
  int n_err    = 0;

  aes_keyexp_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .rk_xsum  (rk_xsum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_din;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: pops expected writes and run records as the DUT produces them
  int busy_cnt = 0;
  int wen_cnt  = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    wr_t e;
    int  exp_busy;
    if (!rst_n) begin
      busy_cnt  = 0;
      wen_cnt   = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) check("done_one_cycle", {31'd0, done}, 32'd0);
      if (busy) busy_cnt++;
      if (mem_wen) begin
        wen_cnt++;
        check("write_expected", {31'd0, wq.size() > 0}, 32'd1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          check("write_addr", {23'd0, mem_addr}, {23'd0, e.addr});
          if (e.care) check($sformatf("write_data_%0d", e.addr), mem_din, e.data);
        end
      end
      if (done) begin
        check("done_expected", {31'd0, rq.size() > 0}, 32'd1);
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        if (rq.size() > 0) begin
          exp_busy = rq.pop_front();
          check("busy_cycles", busy_cnt, exp_busy);
          check("wen_cycles", wen_cnt, 32'd44);
        end
        busy_cnt = 0;
        wen_cnt  = 0;
      end
      prev_done = done;
    end
  end

  task automatic push_run(input logic [7:0][31:0] w, input logic [31:0] w43, input logic c43);
    wr_t e;
    for (int a = 0; a < 44; a++) begin
      e.addr = 9'(128 + a);
      e.data = (a < 8) ? w[a] : w43;
      e.care = (a < 8) || ((a == 43) && c43);
      wq.push_back(e);
    end
    rq.push_back(98);
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic load_key(input logic [31:0] k0, input logic [31:0] k1,
                          input logic [31:0] k2, input logic [31:0] k3);
    mem[4] = k0; mem[5] = k1; mem[6] = k2; mem[7] = k3;
  endtask

  logic [7:0][31:0] fips_w;
  logic [7:0][31:0] zero_w;
  logic [31:0]      xs;

  initial begin
    sbox_w = '{
      32'h637c777b, 32'hf26b6fc5, 32'h3001672b, 32'hfed7ab76,
      32'hca82c97d, 32'hfa5947f0, 32'hadd4a2af, 32'h9ca472c0,
      32'hb7fd9326, 32'h363ff7cc, 32'h34a5e5f1, 32'h71d83115,
      32'h04c723c3, 32'h1896059a, 32'h071280e2, 32'heb27b275,
      32'h09832c1a, 32'h1b6e5aa0, 32'h523bd6b3, 32'h29e32f84,
      32'h53d100ed, 32'h20fcb15b, 32'h6acbbe39, 32'h4a4c58cf,
      32'hd0efaafb, 32'h434d3385, 32'h45f9027f, 32'h503c9fa8,
      32'h51a3408f, 32'h929d38f5, 32'hbcb6da21, 32'h10fff3d2,
      32'hcd0c13ec, 32'h5f974417, 32'hc4a77e3d, 32'h645d1973,
      32'h60814fdc, 32'h222a9088, 32'h46eeb814, 32'hde5e0bdb,
      32'he0323a0a, 32'h4906245c, 32'hc2d3ac62, 32'h9195e479,
      32'he7c8376d, 32'h8dd54ea9, 32'h6c56f4ea, 32'h657aae08,
      32'hba78252e, 32'h1ca6b4c6, 32'he8dd741f, 32'h4bbd8b8a,
      32'h703eb566, 32'h4803f60e, 32'h613557b9, 32'h86c11d9e,
      32'he1f89811, 32'h69d98e94, 32'h9b1e87e9, 32'hce5528df,
      32'h8ca1890d, 32'hbfe64268, 32'h41992d0f, 32'hb054bb16
    };
    for (int a = 0; a < 512; a++) mem[a] = 32'd0;
    for (int a = 0; a < 64; a++) mem[8 + a] = sbox_w[a];
    mem[72] = 32'h01000000; mem[73] = 32'h02000000; mem[74] = 32'h04000000;
    mem[75] = 32'h08000000; mem[76] = 32'h10000000; mem[77] = 32'h20000000;
    mem[78] = 32'h40000000; mem[79] = 32'h80000000; mem[80] = 32'h1b000000;
    mem[81] = 32'h36000000;

    fips_w[0] = 32'h2b7e1516; fips_w[1] = 32'h28aed2a6;
    fips_w[2] = 32'habf71588; fips_w[3] = 32'h09cf4f3c;
    fips_w[4] = 32'ha0fafe17; fips_w[5] = 32'h88542cb1;
    fips_w[6] = 32'h23a33939; fips_w[7] = 32'h2a6c7605;
    zero_w[0] = 32'h0; zero_w[1] = 32'h0; zero_w[2] = 32'h0; zero_w[3] = 32'h0;
    zero_w[4] = 32'h62636363; zero_w[5] = 32'h62636363;
    zero_w[6] = 32'h62636363; zero_w[7] = 32'h62636363;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wen", {31'd0, mem_wen}, 32'd0);
    check("rst_addr", {23'd0, mem_addr}, 32'd0);
    check("rst_din", mem_din, 32'd0);
    check("rst_xsum", rk_xsum, 32'd0);
    rst_n = 1'b1;

    // Test 1/2/6: FIPS-197 key
    load_key(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    push_run(fips_w, 32'hb6630ca6, 1'b1);
    do_start();
    wait_done("t1_done_seen");
    @(posedge clk); #1;
    xs = 32'd0;
    for (int a = 128; a < 172; a++) xs = xs ^ mem[a];
`ifdef KEYEXP_CHECKSUM_EN
    check("t6_xsum", rk_xsum, xs);
`else
    check("t6_xsum_zero", rk_xsum, 32'd0);
`endif
    check("t1_mem171", mem[171], 32'hb6630ca6);

    // Test 3: start pulses mid-run and in DONE are ignored
    push_run(fips_w, 32'hb6630ca6, 1'b1);
    do_start();
    repeat (19) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t3_done_seen");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t3_no_restart", {31'd0, busy}, 32'd0);
    end

    // Test 4: reset mid-run, then a full clean run
    push_run(fips_w, 32'hb6630ca6, 1'b1);
    do_start();
    repeat (49) @(posedge clk);
    #1 rst_n = 1'b0;
    wq.delete();
    rq.delete();
    #1;
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_done", {31'd0, done}, 32'd0);
    check("t4_rst_wen", {31'd0, mem_wen}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    push_run(fips_w, 32'hb6630ca6, 1'b1);
    do_start();
    wait_done("t4_done_seen");
    @(posedge clk); #1;

    // Test 5: all-zero key
    load_key(32'h0, 32'h0, 32'h0, 32'h0);
    push_run(zero_w, 32'h0, 1'b0);
    do_start();
    wait_done("t5_done_seen");
    repeat (3) @(posedge clk);
    #1;
    check("end_wq_empty", wq.size(), 32'd0);
    check("end_rq_empty", rq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
